// File: rtl/rom_bus_ctrl_if.sv
// CPU-side and ROM-array-side signal bundle for rom_bus_ctrl.
// The slave modport is the controller's view; the master modport is the CPU/array side.
interface rom_bus_ctrl_if;
  logic        sync;
  logic [3:0]  data_in;
  logic [3:0]  data_out;
  logic        data_oe;
  logic        mem_rd_en;
  logic [7:0]  mem_addr;
  logic [7:0]  mem_rdata;
  logic [11:0] last_addr;
  logic        sync_error;

  modport slave (
    input  sync,
    input  data_in,
    input  mem_rdata,
    output data_out,
    output data_oe,
    output mem_rd_en,
    output mem_addr,
    output last_addr,
    output sync_error
  );

  modport master (
    output sync,
    output data_in,
    output mem_rdata,
    input  data_out,
    input  data_oe,
    input  mem_rd_en,
    input  mem_addr,
    input  last_addr,
    input  sync_error
  );
endinterface

// File: rtl/rom_bus_ctrl.sv
// ROM bank controller for a 4-bit multiplexed CPU bus: tracks the 8-phase instruction
// cycle, fetches one byte from a synchronous ROM array and returns it as two nibbles.
module rom_bus_ctrl #(
  parameter logic [3:0] CHIP_ID = 4'h0
) (
  input  logic         clock,
  input  logic         reset,
  rom_bus_ctrl_if.slave bus
);

  typedef enum logic {
    UNSYNCED,
    LOCKED
  } state_e;

  localparam logic [2:0] PH_A1 = 3'd0;
  localparam logic [2:0] PH_A2 = 3'd1;
  localparam logic [2:0] PH_A3 = 3'd2;
  localparam logic [2:0] PH_M1 = 3'd3;
  localparam logic [2:0] PH_M2 = 3'd4;
  localparam logic [2:0] PH_X3 = 3'd7;

  state_e      state_q, state_d;
  logic [2:0]  phase_q, phase_d;
  logic        hit_q, hit_d;
  logic [7:0]  addr_q, addr_d;
  logic [3:0]  lo_q, lo_d;
  logic [11:0] last_addr_q, last_addr_d;
  logic        sync_err_q, sync_err_d;

  logic locked;
  logic sync_low;
  logic bank_match;
  logic resync;
  logic lost_sync;
  logic oe;

  assign locked     = (state_q == LOCKED);
  assign sync_low   = ~bus.sync;
  assign bank_match = (bus.data_in == CHIP_ID);
  // A sync anywhere but phase 7 realigns; a missing sync at phase 7 drops lock.
  assign resync     = locked && sync_low && (phase_q != PH_X3);
  assign lost_sync  = locked && !sync_low && (phase_q == PH_X3);

  // NOTE: every _d gets its current value first so no path through the case infers a latch.
  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    hit_d       = hit_q;
    addr_d      = addr_q;
    lo_d        = lo_q;
    last_addr_d = last_addr_q;
    sync_err_d  = sync_err_q;

    case (state_q)
      UNSYNCED: begin
        hit_d = 1'b0;
        if (sync_low) begin
          state_d = LOCKED;
          phase_d = PH_A1;
        end
      end

      LOCKED: begin
        if (resync) begin
          sync_err_d = 1'b1;
          phase_d    = PH_A1;
          hit_d      = 1'b0;
        end else if (lost_sync) begin
          sync_err_d = 1'b1;
          state_d    = UNSYNCED;
          phase_d    = PH_A1;
          hit_d      = 1'b0;
        end else begin
          phase_d = phase_q + 3'd1;
          case (phase_q)
            PH_A1: addr_d[3:0] = bus.data_in;
            PH_A2: addr_d[7:4] = bus.data_in;
            PH_A3: begin
              hit_d = bank_match;
              if (bank_match) last_addr_d = {bus.data_in, addr_q};
            end
            PH_M1: if (hit_q) lo_d = bus.mem_rdata[3:0];
            default: ;
          endcase
        end
      end

      default: state_d = UNSYNCED;
    endcase
  end

  // NOTE: sequential state is updated with non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      // NOTE: reset is synchronous here; it takes effect on the first clock edge it is seen.
      state_q     <= UNSYNCED;
      phase_q     <= PH_A1;
      hit_q       <= 1'b0;
      addr_q      <= 8'h00;
      lo_q        <= 4'h0;
      last_addr_q <= 12'h000;
      sync_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      hit_q       <= hit_d;
      addr_q      <= addr_d;
      lo_q        <= lo_d;
      last_addr_q <= last_addr_d;
      sync_err_q  <= sync_err_d;
    end
  end

  // The array output is forwarded straight through in M1; M2 replays the latched low nibble.
  assign oe            = locked && hit_q && ((phase_q == PH_M1) || (phase_q == PH_M2));
  assign bus.data_oe   = oe;
  assign bus.data_out  = !oe ? 4'h0 :
                         (phase_q == PH_M1) ? bus.mem_rdata[7:4] : lo_q;
  assign bus.mem_rd_en = locked && (phase_q == PH_A3) && bank_match;
  assign bus.mem_addr  = addr_q;
  assign bus.last_addr = last_addr_q;
  assign bus.sync_error = sync_err_q;

endmodule

// File: tb/tb_rom_bus_ctrl.sv
// Bench for rom_bus_ctrl: two instances (bank 0 and bank 2) share one CPU bus; a
// nibble scoreboard per instance holds the data each fetch must return.
module tb_rom_bus_ctrl;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       sync = 1'b1;
  logic [3:0] data_in = 4'h0;

  always #5 clock = ~clock;

  rom_bus_ctrl_if bus0();
  rom_bus_ctrl_if bus2();

  assign bus0.sync    = sync;
  assign bus0.data_in = data_in;
  assign bus2.sync    = sync;
  assign bus2.data_in = data_in;

  logic [7:0] rdata0 = 8'h00;
  logic [7:0] rdata2 = 8'h00;
  assign bus0.mem_rdata = rdata0;
  assign bus2.mem_rdata = rdata2;

  rom_bus_ctrl #(.CHIP_ID(4'h0)) dut0 (.clock(clock), .reset(reset), .bus(bus0));
  rom_bus_ctrl #(.CHIP_ID(4'h2)) dut2 (.clock(clock), .reset(reset), .bus(bus2));

  function automatic logic [7:0] rom_word(input logic [7:0] a);
    return a + 8'h32;
  endfunction

  // Synchronous ROM arrays; output is scrambled whenever no read was issued.
  always @(posedge clock) begin
    if (bus0.mem_rd_en === 1'b1) rdata0 <= rom_word(bus0.mem_addr);
    else                         rdata0 <= ~rdata0;
    if (bus2.mem_rd_en === 1'b1) rdata2 <= rom_word(bus2.mem_addr);
    else                         rdata2 <= ~rdata2;
  end

  int         checks = 0;
  int         errors = 0;
  bit         mon_en = 1'b0;
  logic [3:0] q0[$];
  logic [3:0] q2[$];
  logic [3:0] mexp0, mexp2;
  logic [11:0] last0 = 12'h000;
  logic [11:0] last2 = 12'h000;
  logic        serr = 1'b0;

  // Output monitor: every driven nibble must match the scoreboard, idle bus must be 0.
  always @(negedge clock) begin
    if (mon_en) begin
      checks++;
      if (bus0.data_oe === 1'b1) begin
        if (q0.size() == 0) begin
          errors++;
          $display("FAIL oe0_unexpected: data_oe=1 data_out=%h, required data_oe=0", bus0.data_out);
        end else begin
          mexp0 = q0.pop_front();
          if (bus0.data_out !== mexp0) begin
            errors++;
            $display("FAIL data_out0: got %h, expected %h", bus0.data_out, mexp0);
          end
        end
      end else if (bus0.data_oe !== 1'b0 || bus0.data_out !== 4'h0) begin
        errors++;
        $display("FAIL idle0: data_oe=%b data_out=%h, expected 0/0", bus0.data_oe, bus0.data_out);
      end
      checks++;
      if (bus2.data_oe === 1'b1) begin
        if (q2.size() == 0) begin
          errors++;
          $display("FAIL oe2_unexpected: data_oe=1 data_out=%h, required data_oe=0", bus2.data_out);
        end else begin
          mexp2 = q2.pop_front();
          if (bus2.data_out !== mexp2) begin
            errors++;
            $display("FAIL data_out2: got %h, expected %h", bus2.data_out, mexp2);
          end
        end
      end else if (bus2.data_oe !== 1'b0 || bus2.data_out !== 4'h0) begin
        errors++;
        $display("FAIL idle2: data_oe=%b data_out=%h, expected 0/0", bus2.data_oe, bus2.data_out);
      end
    end
  end

  task automatic cycle(input logic s, input logic [3:0] d, input logic r);
    @(posedge clock);
    #1;
    sync    = s;
    data_in = d;
    reset   = r;
    @(negedge clock);
  endtask

  // One instruction cycle starting at phase 0; stops after sync_ph or rst_ph if reached.
  task automatic run_cycle(input logic [7:0] a, input logic [3:0] bank,
                           input int sync_ph, input int rst_ph);
    logic       hit0, hit2;
    logic [3:0] d;
    logic [7:0] w;
    hit0 = (bank == 4'h0);
    hit2 = (bank == 4'h2);
    w    = rom_word(a);
    for (int ph = 0; ph < 8; ph++) begin
      d = (ph == 0) ? a[3:0] : (ph == 1) ? a[7:4] : (ph == 2) ? bank : 4'h0;
      @(posedge clock);
      #1;
      sync    = (ph == sync_ph) ? 1'b0 : 1'b1;
      data_in = d;
      reset   = (ph == rst_ph);
      if (ph == 3) begin
        if (hit0) begin q0.push_back(w[7:4]); last0 = {4'h0, a}; end
        if (hit2) begin q2.push_back(w[7:4]); last2 = {4'h2, a}; end
      end
      if (ph == 4) begin
        if (hit0) q0.push_back(w[3:0]);
        if (hit2) q2.push_back(w[3:0]);
      end
      @(negedge clock);
      checks++;
      if (bus0.mem_rd_en !== (ph == 2 && hit0)) begin
        errors++;
        $display("FAIL rd_en0 ph%0d: got %b, expected %b", ph, bus0.mem_rd_en, (ph == 2 && hit0));
      end
      checks++;
      if (bus2.mem_rd_en !== (ph == 2 && hit2)) begin
        errors++;
        $display("FAIL rd_en2 ph%0d: got %b, expected %b", ph, bus2.mem_rd_en, (ph == 2 && hit2));
      end
      if (ph == 2 && hit0) begin
        checks++;
        if (bus0.mem_addr !== a) begin
          errors++;
          $display("FAIL mem_addr0: got %h, expected %h", bus0.mem_addr, a);
        end
      end
      if (ph == 2 && hit2) begin
        checks++;
        if (bus2.mem_addr !== a) begin
          errors++;
          $display("FAIL mem_addr2: got %h, expected %h", bus2.mem_addr, a);
        end
      end
      if (ph == 3) begin
        checks++;
        if (bus0.last_addr !== last0 || bus2.last_addr !== last2) begin
          errors++;
          $display("FAIL last_addr: got %h/%h, expected %h/%h",
                   bus0.last_addr, bus2.last_addr, last0, last2);
        end
      end
      if (ph == sync_ph || ph == rst_ph) break;
    end
  endtask

  task automatic check_flags(input string name);
    checks++;
    if (bus0.sync_error !== serr || bus2.sync_error !== serr) begin
      errors++;
      $display("FAIL %s sync_error: got %b/%b, expected %b", name,
               bus0.sync_error, bus2.sync_error, serr);
    end
  endtask

  task automatic apply_reset();
    cycle(1'b1, 4'h0, 1'b1);
    cycle(1'b1, 4'h0, 1'b1);
    last0 = 12'h000;
    last2 = 12'h000;
    serr  = 1'b0;
    checks++;
    if (bus0.data_oe !== 1'b0 || bus0.data_out !== 4'h0 || bus0.mem_rd_en !== 1'b0 ||
        bus2.data_oe !== 1'b0 || bus2.data_out !== 4'h0 || bus2.mem_rd_en !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: oe=%b/%b out=%h/%h rd=%b/%b, expected all 0",
               bus0.data_oe, bus2.data_oe, bus0.data_out, bus2.data_out,
               bus0.mem_rd_en, bus2.mem_rd_en);
    end
    checks++;
    if (bus0.last_addr !== 12'h000 || bus2.last_addr !== 12'h000) begin
      errors++;
      $display("FAIL reset_last_addr: got %h/%h, expected 000/000", bus0.last_addr, bus2.last_addr);
    end
    check_flags("reset");
    cycle(1'b1, 4'h0, 1'b0);
  endtask

  task automatic test_reset();
    apply_reset();
    mon_en = 1'b1;
  endtask

  task automatic test_unsynced();
    for (int i = 0; i < 20; i++) begin
      cycle(1'b1, 4'(i), 1'b0);
      checks++;
      if (bus0.mem_rd_en !== 1'b0 || bus2.mem_rd_en !== 1'b0 ||
          bus0.data_oe !== 1'b0 || bus2.data_oe !== 1'b0) begin
        errors++;
        $display("FAIL unsynced_%0d: rd=%b/%b oe=%b/%b, expected 0", i,
                 bus0.mem_rd_en, bus2.mem_rd_en, bus0.data_oe, bus2.data_oe);
      end
    end
    cycle(1'b0, 4'h0, 1'b0);
    run_cycle(8'h3C, 4'h0, 7, 99);
  endtask

  task automatic test_fetch_hit();
    run_cycle(8'hA5, 4'h0, 7, 99);
    checks++;
    if (bus0.last_addr !== 12'h0A5) begin
      errors++;
      $display("FAIL last_addr_a5: got %h, expected 0a5", bus0.last_addr);
    end
    run_cycle(8'h00, 4'h0, 7, 99);
    run_cycle(8'hFF, 4'h2, 7, 99);
    run_cycle(8'h5A, 4'h2, 7, 99);
  endtask

  task automatic test_fetch_miss();
    run_cycle(8'h77, 4'h3, 7, 99);
    checks++;
    if (bus2.last_addr !== 12'h25A || bus0.last_addr !== 12'h000) begin
      errors++;
      $display("FAIL miss_last_addr: got %h/%h, expected 000/25a", bus0.last_addr, bus2.last_addr);
    end
    run_cycle(8'h12, 4'hF, 7, 99);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++)
      run_cycle(8'($urandom), 4'($urandom_range(0, 3)), 7, 99);
    check_flags("back_to_back");
  endtask

  task automatic test_resync();
    run_cycle(8'hC3, 4'h0, 4, 99);
    serr = 1'b1;
    run_cycle(8'h1E, 4'h0, 7, 99);
    check_flags("resync");
    run_cycle(8'h2B, 4'h2, 7, 99);
  endtask

  task automatic test_lost_sync();
    apply_reset();
    cycle(1'b0, 4'h0, 1'b0);
    run_cycle(8'h81, 4'h0, 7, 99);
    check_flags("pre_lost");
    run_cycle(8'h42, 4'h2, 8, 99);
    serr = 1'b1;
    for (int i = 0; i < 12; i++) begin
      cycle(1'b1, (i % 2 == 0) ? 4'h0 : 4'h2, 1'b0);
      checks++;
      if (bus0.mem_rd_en !== 1'b0 || bus2.mem_rd_en !== 1'b0) begin
        errors++;
        $display("FAIL lost_rd_en_%0d: got %b/%b, expected 0/0", i, bus0.mem_rd_en, bus2.mem_rd_en);
      end
    end
    check_flags("lost_idle");
    cycle(1'b0, 4'h0, 1'b0);
    run_cycle(8'hE4, 4'h0, 7, 99);
    check_flags("lost_relock");
  endtask

  task automatic test_reset_mid_fetch();
    run_cycle(8'h96, 4'h0, 7, 3);
    cycle(1'b1, 4'h0, 1'b0);
    last0 = 12'h000;
    last2 = 12'h000;
    serr  = 1'b0;
    checks++;
    if (bus0.data_oe !== 1'b0 || bus0.data_out !== 4'h0) begin
      errors++;
      $display("FAIL midreset_oe: oe=%b out=%h, expected 0/0", bus0.data_oe, bus0.data_out);
    end
    checks++;
    if (bus0.last_addr !== 12'h000) begin
      errors++;
      $display("FAIL midreset_last_addr: got %h, expected 000", bus0.last_addr);
    end
    check_flags("midreset");
    for (int i = 0; i < 3; i++) cycle(1'b1, 4'h0, 1'b0);
    cycle(1'b0, 4'h0, 1'b0);
    run_cycle(8'h69, 4'h2, 7, 99);
    run_cycle(8'hB7, 4'h0, 7, 99);
  endtask

  initial begin
    test_reset();
    test_unsynced();
    test_fetch_hit();
    test_fetch_miss();
    test_back_to_back();
    test_resync();
    test_lost_sync();
    test_reset_mid_fetch();
    cycle(1'b1, 4'h0, 1'b0);
    checks++;
    if (q0.size() != 0 || q2.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d/%0d nibbles never returned, expected 0/0",
               q0.size(), q2.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rom_bus_ctrl.md
ROM_BUS_CTRL -- requirements
Module: rom_bus_ctrl

Interface
REQ-001 SHALL have parameter CHIP_ID, default 4'h0, the ROM bank this block answers for (address bits [11:8]).
REQ-002 SHALL have port clock  input  1  sole clock; all state updates on posedge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port sync  input  1  CPU sync, active-low; low for exactly one clock, during CPU subcycle 7.
REQ-005 SHALL have port data_in  input  4  CPU bus nibble: address during A1-A3.
REQ-006 SHALL have port data_out  output  4  nibble driven to the CPU during M1/M2.
REQ-007 SHALL have port data_oe  output  1  high when data_out is valid and owned by this block.
REQ-008 SHALL have port mem_rd_en  output  1  one-cycle read strobe to the synchronous ROM array.
REQ-009 SHALL have port mem_addr  output  8  ROM array word address within the bank.
REQ-010 SHALL have port mem_rdata  input  8  ROM word; valid exactly one clock after mem_rd_en.
REQ-011 SHALL have port last_addr  output  12  full address of the most recent fetch addressed to this bank.
REQ-012 SHALL have port sync_error  output  1  sticky flag: sync pulse arrived out of phase.

Function
REQ-013 SHALL keep a 3-bit phase counter: 0-2 = A1-A3, 3-4 = M1-M2, 5-7 = X1-X3; it increments by 1 per clock and wraps 7->0.
REQ-014 SHALL have two states, UNSYNCED and LOCKED; reset enters UNSYNCED.
REQ-015 In UNSYNCED: sync sampled low -> phase <= 0, state <= LOCKED; otherwise phase is don't-care and data_oe, mem_rd_en stay 0.
REQ-016 In LOCKED: sync sampled low with phase==7 is normal; phase wraps to 0.
REQ-017 In LOCKED: sync sampled low with phase!=7 -> sync_error <= 1, phase <= 0, remain LOCKED (realign).
REQ-018 In LOCKED: sync sampled high with phase==7 -> sync_error <= 1, state <= UNSYNCED.
REQ-019 sync_error SHALL be cleared only by reset.
REQ-020 At the edge ending phase 0, SHALL capture data_in as addr[3:0]; at the edge ending phase 1, as addr[7:4].
REQ-021 During phase 2 (LOCKED only), mem_rd_en SHALL be combinationally high iff data_in == CHIP_ID; mem_addr = {addr[7:4], addr[3:0]}.
REQ-022 At the edge ending phase 2, SHALL register hit = (data_in == CHIP_ID) and, on hit, last_addr <= {data_in, addr[7:0]}.
REQ-023 During phase 3 with hit: data_oe = 1, data_out = mem_rdata[7:4] (combinational from array output).
REQ-024 At the edge ending phase 3 with hit, SHALL latch mem_rdata[3:0] into a low-nibble register.
REQ-025 During phase 4 with hit: data_oe = 1, data_out = latched low nibble.
REQ-026 In all other phases, or without hit, or in UNSYNCED: data_oe = 0 and data_out = 4'h0.
REQ-027 SHALL NOT alter addressing for two-word instructions; every instruction cycle is an independent fetch.
REQ-028 If the resync of REQ-017 occurs mid-fetch, the in-progress fetch SHALL be abandoned: hit <= 0, no further data_oe that cycle.

Reset
REQ-029 On reset: state=UNSYNCED, phase=0, hit=0, addr=0, low-nibble register=0, last_addr=12'h000, sync_error=0; data_oe=0, data_out=0, mem_rd_en=0.
REQ-030 Reset asserted mid-fetch SHALL deassert data_oe on the following clock and discard the fetch.

Verification
REQ-031 CHIP_ID=0, lock, drive A1=4'h5, A2=4'hA, A3=4'h0, array returns 8'hD7 -> mem_rd_en in phase 2, mem_addr=8'hA5; data_out=4'hD (oe=1) in phase 3, 4'h7 in phase 4; last_addr=12'h0A5.
REQ-032 CHIP_ID=2, A3=4'h3 -> mem_rd_en=0, data_oe=0 for the whole cycle; last_addr unchanged.
REQ-033 No sync after reset for 20 clocks, any data_in -> data_oe and mem_rd_en stay 0; first sync low -> next clock is phase 0 and fetch proceeds.
REQ-034 Locked; sync low injected at phase 4 -> sync_error=1, phase 0 next clock, no data_oe for remainder of that cycle, next cycle fetches normally.
REQ-035 Locked; sync omitted at phase 7 -> sync_error=1, UNSYNCED, no data_oe until the next sync low; sync_error stays 1 until reset.
REQ-036 Reset during phase 3 of a hit fetch -> data_oe=0 next clock, all registers at REQ-029 values.
